// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: states, opcodes, ALU codes and mux selects.
// The cz_cond helper resolves the conditional write-back field of ADD/NDU against the flags.
package ctrl_pkg;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_EXEC_R   = 4'd2;
    localparam logic [3:0] ST_WB_R     = 4'd3;
    localparam logic [3:0] ST_EXEC_I   = 4'd4;
    localparam logic [3:0] ST_WB_I     = 4'd5;
    localparam logic [3:0] ST_MEM_ADDR = 4'd6;
    localparam logic [3:0] ST_MEM_RD   = 4'd7;
    localparam logic [3:0] ST_MEM_WR   = 4'd8;
    localparam logic [3:0] ST_WB_LD    = 4'd9;
    localparam logic [3:0] ST_JUMP     = 4'd10;
    localparam logic [3:0] ST_BR_CMP   = 4'd11;
    localparam logic [3:0] ST_BR_TAKE  = 4'd12;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_ADI = 4'b0001;
    localparam logic [3:0] OP_NDU = 4'b0010;
    localparam logic [3:0] OP_LW  = 4'b0100;
    localparam logic [3:0] OP_SW  = 4'b0101;
    localparam logic [3:0] OP_JAL = 4'b1000;
    localparam logic [3:0] OP_BEQ = 4'b1100;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_NAND = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    localparam logic [2:0] ALU_A_NONE = 3'b000;
    localparam logic [2:0] ALU_A_RA   = 3'b001;
    localparam logic [2:0] ALU_A_BR   = 3'b101;

    localparam logic [1:0] ALU_B_RB  = 2'b00;
    localparam logic [1:0] ALU_B_IMM = 2'b10;

    localparam logic [1:0] WADD_NONE = 2'b00;
    localparam logic [1:0] WADD_RC   = 2'b01;
    localparam logic [1:0] WADD_RA   = 2'b10;
    localparam logic [1:0] WADD_RB   = 2'b11;

    localparam logic [1:0] CZ_ALWAYS = 2'b00;
    localparam logic [1:0] CZ_ZERO   = 2'b01;
    localparam logic [1:0] CZ_CARRY  = 2'b10;
    localparam logic [1:0] CZ_BAD    = 2'b11;

    function automatic logic cz_cond(input logic [1:0] cz, input logic carry, input logic zero);
        logic c;
        c = 1'b0;
        case (cz)
            CZ_ALWAYS: c = 1'b1;
            CZ_CARRY:  c = carry;
            CZ_ZERO:   c = zero;
            default:   c = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait-state counter: clears on request, counts stalled cycles,
// flags when the count has reached the timeout limit.
module mem_wait_timer #(
    parameter int CNT_W       = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_timeout
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_timeout = (r_cnt == CNT_W'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle controller for the 16-bit RISC core: decodes IR opcodes and sequences
// datapath strobes, with memory wait/timeout handling and illegal-opcode reporting.
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [DATA_W-1:0] i_ir,
    input  logic              i_carry,
    input  logic              i_zero,
    input  logic              i_alu_eq,
    input  logic              i_mem_ready,
    output logic [3:0]        o_state,
    output logic              o_ir_wen,
    output logic              o_pc_wen,
    output logic              o_rf_wen,
    output logic              o_mem_read,
    output logic              o_mem_write,
    output logic [1:0]        o_alu_op,
    output logic [2:0]        o_alu_a_sel,
    output logic [1:0]        o_alu_b_sel,
    output logic [1:0]        o_rf_wadd_sel,
    output logic              o_rf_din_sel,
    output logic              o_cz_en,
    output logic              o_illegal,
    output logic              o_bus_err
);

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       r_cond;
    logic       r_bus_err;
    logic [3:0] w_opcode;
    logic [1:0] w_cz;
    logic       w_is_r;
    logic       w_legal;
    logic       w_illegal;
    logic       w_wait_st;
    logic       w_timeout;
    logic       w_abort;
    logic       w_tmr_en;
    logic       w_tmr_clr;
    logic       w_unused_ir;

    assign w_opcode    = i_ir[DATA_W-1 -: 4];
    assign w_cz        = i_ir[1:0];
    assign w_unused_ir = ^i_ir[DATA_W-5:2];

    assign w_is_r  = (w_opcode == OP_ADD) || (w_opcode == OP_NDU);
    assign w_legal = w_is_r || (w_opcode == OP_ADI) || (w_opcode == OP_LW) ||
                     (w_opcode == OP_SW) || (w_opcode == OP_JAL) || (w_opcode == OP_BEQ);
    assign w_illegal = (r_state == ST_DECODE) && (!w_legal || (w_is_r && (w_cz == CZ_BAD)));

    // Every state that waits on mem_ready shares the one timer.
    assign w_wait_st = (r_state == ST_FETCH) || (r_state == ST_MEM_RD) || (r_state == ST_MEM_WR);
    assign w_tmr_en  = w_wait_st && !i_mem_ready && !w_timeout;
    assign w_abort   = w_wait_st && !i_mem_ready && w_timeout;
    assign w_tmr_clr = ((w_next == ST_FETCH) || (w_next == ST_MEM_RD) || (w_next == ST_MEM_WR)) &&
                       ((w_next != r_state) || w_abort);

    mem_wait_timer #(
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clr     (w_tmr_clr),
        .i_en      (w_tmr_en),
        .o_timeout (w_timeout)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH: begin
                if (i_mem_ready)  w_next = ST_DECODE;
                else if (w_abort) w_next = ST_FETCH;
            end
            ST_DECODE: begin
                if (w_illegal) begin
                    w_next = ST_FETCH;
                end else begin
                    case (w_opcode)
                        OP_ADD, OP_NDU: w_next = ST_EXEC_R;
                        OP_ADI:         w_next = ST_EXEC_I;
                        OP_LW, OP_SW:   w_next = ST_MEM_ADDR;
                        OP_JAL:         w_next = ST_JUMP;
                        OP_BEQ:         w_next = ST_BR_CMP;
                        default:        w_next = ST_FETCH;
                    endcase
                end
            end
            ST_EXEC_R:   w_next = ST_WB_R;
            ST_WB_R:     w_next = ST_FETCH;
            ST_EXEC_I:   w_next = ST_WB_I;
            ST_WB_I:     w_next = ST_FETCH;
            ST_MEM_ADDR: w_next = (w_opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD: begin
                if (i_mem_ready)  w_next = ST_WB_LD;
                else if (w_abort) w_next = ST_FETCH;
            end
            ST_MEM_WR: begin
                if (i_mem_ready || w_abort) w_next = ST_FETCH;
            end
            ST_WB_LD:    w_next = ST_FETCH;
            ST_JUMP:     w_next = ST_FETCH;
            ST_BR_CMP:   w_next = i_alu_eq ? ST_BR_TAKE : ST_FETCH;
            ST_BR_TAKE:  w_next = ST_FETCH;
            default:     w_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_FETCH;
            r_cond    <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_bus_err <= w_abort;
            if (r_state == ST_DECODE) begin
                r_cond <= cz_cond(w_cz, i_carry, i_zero);
            end
        end
    end

    always_comb begin
        o_ir_wen      = 1'b0;
        o_pc_wen      = 1'b0;
        o_rf_wen      = 1'b0;
        o_mem_read    = 1'b0;
        o_mem_write   = 1'b0;
        o_alu_op      = ALU_ADD;
        o_alu_a_sel   = ALU_A_NONE;
        o_alu_b_sel   = ALU_B_RB;
        o_rf_wadd_sel = WADD_NONE;
        o_rf_din_sel  = 1'b0;
        o_cz_en       = 1'b0;
        case (r_state)
            ST_FETCH: begin
                o_mem_read = 1'b1;
                o_ir_wen   = i_mem_ready;
                o_pc_wen   = i_mem_ready;
            end
            ST_EXEC_R: begin
                o_alu_op    = (w_opcode == OP_NDU) ? ALU_NAND : ALU_ADD;
                o_alu_a_sel = ALU_A_RA;
                o_cz_en     = r_cond;
            end
            ST_WB_R: begin
                o_rf_wen      = r_cond;
                o_rf_wadd_sel = WADD_RC;
            end
            ST_EXEC_I: begin
                o_alu_b_sel = ALU_B_IMM;
                o_cz_en     = 1'b1;
            end
            ST_WB_I: begin
                o_rf_wen      = 1'b1;
                o_rf_wadd_sel = WADD_RB;
            end
            ST_MEM_ADDR: o_alu_b_sel = ALU_B_IMM;
            ST_MEM_RD:   o_mem_read  = 1'b1;
            ST_MEM_WR:   o_mem_write = 1'b1;
            ST_WB_LD: begin
                o_rf_wen      = 1'b1;
                o_rf_din_sel  = 1'b1;
                o_rf_wadd_sel = WADD_RC;
                o_cz_en       = 1'b1;
            end
            ST_JUMP: begin
                o_rf_wen      = 1'b1;
                o_rf_wadd_sel = WADD_RA;
                o_pc_wen      = 1'b1;
            end
            ST_BR_CMP:   o_alu_op = ALU_SUB;
            ST_BR_TAKE: begin
                o_pc_wen    = 1'b1;
                o_alu_a_sel = ALU_A_BR;
            end
            default: ;
        endcase
    end

    assign o_state   = r_state;
    assign o_illegal = w_illegal;
    assign o_bus_err = r_bus_err;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench: stimulus pushes the expected output vector for each driven cycle,
// a negedge monitor pops and compares it against the DUT outputs.
module tb_multicycle_ctrl_fsm;
    import ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [15:0] i_ir = '0;
    logic        i_carry = 1'b0;
    logic        i_zero = 1'b0;
    logic        i_alu_eq = 1'b0;
    logic        i_mem_ready = 1'b0;
    logic [3:0]  o_state;
    logic        o_ir_wen, o_pc_wen, o_rf_wen, o_mem_read, o_mem_write;
    logic [1:0]  o_alu_op, o_alu_b_sel, o_rf_wadd_sel;
    logic [2:0]  o_alu_a_sel;
    logic        o_rf_din_sel, o_cz_en, o_illegal, o_bus_err;

    logic [21:0] exp_q[$];
    logic [21:0] exp_v, act_v;
    logic [3:0]  cur_op = OP_ADD;
    int          n_tests = 0;
    int          n_fail = 0;
    int          n_cyc = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.DATA_W(16), .MEM_TIMEOUT(15), .CNT_W(4)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_ir(i_ir), .i_carry(i_carry), .i_zero(i_zero),
        .i_alu_eq(i_alu_eq), .i_mem_ready(i_mem_ready), .o_state(o_state),
        .o_ir_wen(o_ir_wen), .o_pc_wen(o_pc_wen), .o_rf_wen(o_rf_wen),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_alu_op(o_alu_op),
        .o_alu_a_sel(o_alu_a_sel), .o_alu_b_sel(o_alu_b_sel), .o_rf_wadd_sel(o_rf_wadd_sel),
        .o_rf_din_sel(o_rf_din_sel), .o_cz_en(o_cz_en), .o_illegal(o_illegal),
        .o_bus_err(o_bus_err)
    );

    // Expected outputs per state, written from the state/output table of the controller.
    function automatic logic [21:0] build(input logic [3:0] st, input logic mr,
                                          input logic cnd, input logic ill, input logic berr);
        logic irw, pcw, rfw, mrd, mwr, din, cze;
        logic [1:0] op, bs, wa;
        logic [2:0] as;
        {irw, pcw, rfw, mrd, mwr, din, cze} = '0;
        op = 2'b00; bs = 2'b00; wa = 2'b00; as = 3'b000;
        case (st)
            ST_FETCH:    begin mrd = 1'b1; irw = mr; pcw = mr; end
            ST_EXEC_R:   begin op = (cur_op == OP_NDU) ? 2'b01 : 2'b00; as = 3'b001; cze = cnd; end
            ST_WB_R:     begin rfw = cnd; wa = 2'b01; end
            ST_EXEC_I:   begin bs = 2'b10; cze = 1'b1; end
            ST_WB_I:     begin rfw = 1'b1; wa = 2'b11; end
            ST_MEM_ADDR: bs = 2'b10;
            ST_MEM_RD:   mrd = 1'b1;
            ST_MEM_WR:   mwr = 1'b1;
            ST_WB_LD:    begin rfw = 1'b1; din = 1'b1; wa = 2'b01; cze = 1'b1; end
            ST_JUMP:     begin rfw = 1'b1; wa = 2'b10; pcw = 1'b1; end
            ST_BR_CMP:   op = 2'b10;
            ST_BR_TAKE:  begin pcw = 1'b1; as = 3'b101; end
            default: ;
        endcase
        return {st, irw, pcw, rfw, mrd, mwr, op, as, bs, wa, din, cze, ill, berr};
    endfunction

    always @(negedge clk) begin
        n_cyc++;
        if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            act_v = {o_state, o_ir_wen, o_pc_wen, o_rf_wen, o_mem_read, o_mem_write, o_alu_op,
                     o_alu_a_sel, o_alu_b_sel, o_rf_wadd_sel, o_rf_din_sel, o_cz_en,
                     o_illegal, o_bus_err};
            n_tests++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL out_vec t=%0t state got=%0d exp=%0d vec got=%h exp=%h",
                         $time, act_v[21:18], exp_v[21:18], act_v, exp_v);
            end
        end
    end

    // Drive one cycle (called just after a rising edge) and queue its expected outputs.
    task automatic cyc(input logic mr, input logic [3:0] st, input logic cnd,
                       input logic ill, input logic berr);
        i_mem_ready = mr;
        exp_q.push_back(build(st, mr, cnd, ill, berr));
        @(posedge clk);
        #1;
    endtask

    task automatic r_type(input logic [3:0] op, input logic [1:0] cz, input logic c,
                          input logic z, input logic exp_cond);
        i_ir = {op, 10'd0, cz}; cur_op = op; i_carry = c; i_zero = z;
        cyc(1, ST_FETCH, 0, 0, 0);
        cyc(1, ST_DECODE, 0, 0, 0);
        cyc(1, ST_EXEC_R, exp_cond, 0, 0);
        cyc(1, ST_WB_R, exp_cond, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

    initial begin
        i_reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        i_reset = 1'b0;

        cyc(0, ST_FETCH, 0, 0, 0);

        r_type(OP_ADD, 2'b00, 0, 0, 1);
        r_type(OP_ADD, 2'b10, 0, 0, 0);
        r_type(OP_ADD, 2'b10, 1, 0, 1);
        r_type(OP_NDU, 2'b01, 0, 1, 1);
        r_type(OP_NDU, 2'b01, 1, 0, 0);

        i_ir = {OP_ADI, 12'h045}; cur_op = OP_ADI;
        cyc(1, ST_FETCH, 0, 0, 0);
        cyc(1, ST_DECODE, 0, 0, 0);
        cyc(1, ST_EXEC_I, 0, 0, 0);
        cyc(1, ST_WB_I, 0, 0, 0);

        // LW with three stalled read cycles.
        i_ir = {OP_LW, 12'h083}; cur_op = OP_LW;
        cyc(1, ST_FETCH, 0, 0, 0);
        cyc(1, ST_DECODE, 0, 0, 0);
        cyc(1, ST_MEM_ADDR, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, ST_MEM_RD, 0, 0, 0);
        cyc(1, ST_MEM_RD, 0, 0, 0);
        cyc(1, ST_WB_LD, 0, 0, 0);

        // SW timeout: 16 MEM_WR cycles (count 0..15), then bus_err in FETCH.
        i_ir = {OP_SW, 12'h011}; cur_op = OP_SW;
        cyc(1, ST_FETCH, 0, 0, 0);
        cyc(1, ST_DECODE, 0, 0, 0);
        cyc(1, ST_MEM_ADDR, 0, 0, 0);
        for (int i = 0; i < 16; i++) cyc(0, ST_MEM_WR, 0, 0, 0);
        cyc(0, ST_FETCH, 0, 0, 1);
        cyc(0, ST_FETCH, 0, 0, 0);

        // SW ready on the same cycle the count reaches the limit: success, no bus_err.
        cyc(1, ST_FETCH, 0, 0, 0);
        cyc(1, ST_DECODE, 0, 0, 0);
        cyc(1, ST_MEM_ADDR, 0, 0, 0);
        for (int i = 0; i < 15; i++) cyc(0, ST_MEM_WR, 0, 0, 0);
        cyc(1, ST_MEM_WR, 0, 0, 0);
        cyc(0, ST_FETCH, 0, 0, 0);

        i_ir = {OP_JAL, 12'h123}; cur_op = OP_JAL;
        cyc(1, ST_FETCH, 0, 0, 0);
        cyc(1, ST_DECODE, 0, 0, 0);
        cyc(1, ST_JUMP, 0, 0, 0);

        i_ir = {OP_BEQ, 12'h0a1}; cur_op = OP_BEQ; i_alu_eq = 1'b0;
        cyc(1, ST_FETCH, 0, 0, 0);
        cyc(1, ST_DECODE, 0, 0, 0);
        cyc(1, ST_BR_CMP, 0, 0, 0);
        i_alu_eq = 1'b1;
        cyc(1, ST_FETCH, 0, 0, 0);
        cyc(1, ST_DECODE, 0, 0, 0);
        cyc(1, ST_BR_CMP, 0, 0, 0);
        cyc(1, ST_BR_TAKE, 0, 0, 0);
        i_alu_eq = 1'b0;

        i_ir = 16'hf000; cur_op = 4'hf;
        cyc(1, ST_FETCH, 0, 0, 0);
        cyc(1, ST_DECODE, 0, 1, 0);
        cyc(0, ST_FETCH, 0, 0, 0);

        i_ir = {OP_ADD, 10'd0, 2'b11}; cur_op = OP_ADD;
        cyc(1, ST_FETCH, 0, 0, 0);
        cyc(1, ST_DECODE, 0, 1, 0);
        cyc(0, ST_FETCH, 0, 0, 0);

        // Reset while in EXEC_I abandons the instruction.
        i_ir = {OP_ADI, 12'h005}; cur_op = OP_ADI;
        cyc(1, ST_FETCH, 0, 0, 0);
        cyc(1, ST_DECODE, 0, 0, 0);
        i_reset = 1'b1;
        cyc(0, ST_EXEC_I, 0, 0, 0);
        i_reset = 1'b0;
        cyc(0, ST_FETCH, 0, 0, 0);
        cyc(0, ST_FETCH, 0, 0, 0);

        repeat (3) @(posedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain left=%0d exp=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
